// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_pkg : shared constants, state encoding and code values for the  |
// |            guessing-game referee and correlation stage.              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package game_pkg;

  localparam int SIZE   = 6;
  localparam int ROUNDS = 5;
  localparam int CNT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_GUESS = 3'd1,
    ST_EVAL       = 3'd2,
    ST_SAMPLE     = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  localparam logic [1:0] CMP_INVALID = 2'b00;
  localparam logic [1:0] CMP_FIRST   = 2'b01;
  localparam logic [1:0] CMP_SECOND  = 2'b10;
  localparam logic [1:0] CMP_TIE     = 2'b11;

  localparam logic [1:0] HIT_NONE    = 2'b00;
  localparam logic [1:0] HIT_FIRST   = 2'b01;
  localparam logic [1:0] HIT_SECOND  = 2'b10;
  localparam logic [1:0] HIT_BOTH    = 2'b11;

  localparam logic [1:0] WIN_NONE    = 2'b00;
  localparam logic [1:0] WIN_FIRST   = 2'b01;
  localparam logic [1:0] WIN_SECOND  = 2'b10;
  localparam logic [1:0] WIN_DRAW    = 2'b11;

  function automatic logic [1:0] win_of(input logic [CNT_W-1:0] first,
                                        input logic [CNT_W-1:0] second);
    if (first > second)      return WIN_FIRST;
    else if (first < second) return WIN_SECOND;
    else                     return WIN_DRAW;
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_referee_round_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | round_scoreboard : score, history and round bookkeeping plus the     |
// |                    end-of-game winner decision, updated on sample.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module round_scoreboard #(
  parameter int ROUNDS = game_pkg::ROUNDS
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       clear,
  input  logic                       sample,
  input  logic [1:0]                 cmp_code,
  input  logic [1:0]                 hit_code,
  output logic [game_pkg::CNT_W-1:0] round,
  output logic [game_pkg::CNT_W-1:0] score_first,
  output logic [game_pkg::CNT_W-1:0] score_second,
  output logic [2*ROUNDS-1:0]        history,
  output logic [1:0]                 winner,
  output logic                       protocol_error,
  output logic                       finish
);
  import game_pkg::*;

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(ROUNDS);

  logic [CNT_W-1:0]   w_first_nx;
  logic [CNT_W-1:0]   w_second_nx;
  logic [CNT_W-1:0]   w_round_nx;
  logic [2*ROUNDS-1:0] w_hist_nx;
  logic [1:0]         w_win_nx;

  always_comb begin
    w_first_nx  = score_first;
    w_second_nx = score_second;
    w_round_nx  = round;
    w_hist_nx   = history;
    if (cmp_code == CMP_FIRST && score_first != C_MAX)
      w_first_nx = score_first + CNT_W'(1);
    if (cmp_code == CMP_SECOND && score_second != C_MAX)
      w_second_nx = score_second + CNT_W'(1);
    if (round != C_MAX)
      w_round_nx = round + CNT_W'(1);
    // Loop over slots keeps the write in range once Round has saturated.
    for (int k = 0; k < ROUNDS; k++)
      if (round == CNT_W'(k))
        w_hist_nx[2*k +: 2] = cmp_code;
    finish   = (hit_code != HIT_NONE) || (w_round_nx == C_MAX);
    w_win_nx = (hit_code != HIT_NONE) ? hit_code : win_of(w_first_nx, w_second_nx);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      round          <= '0;
      score_first    <= '0;
      score_second   <= '0;
      history        <= '0;
      winner         <= WIN_NONE;
      protocol_error <= 1'b0;
    end else if (clear) begin
      round          <= '0;
      score_first    <= '0;
      score_second   <= '0;
      history        <= '0;
      winner         <= WIN_NONE;
      protocol_error <= 1'b0;
    end else if (sample) begin
      round        <= w_round_nx;
      score_first  <= w_first_nx;
      score_second <= w_second_nx;
      history      <= w_hist_nx;
      if (finish)
        winner <= w_win_nx;
      if (cmp_code == CMP_INVALID)
        protocol_error <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_referee.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_referee : round sequencer for the two-player guessing game;     |
// |                drives the correlation stage and the scoreboard.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module game_referee #(
  parameter int ROUNDS = game_pkg::ROUNDS
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Guess_Valid,
  output logic                       Guess_Ready,
  output logic                       Eval,
  input  logic [1:0]                 Cmp_Code,
  input  logic [1:0]                 Hit_Code,
  output logic [game_pkg::CNT_W-1:0] Round,
  output logic [game_pkg::CNT_W-1:0] Score_First,
  output logic [game_pkg::CNT_W-1:0] Score_Second,
  output logic [2*ROUNDS-1:0]        History,
  output logic [1:0]                 Winner,
  output logic                       Game_Over,
  output logic                       Protocol_Error
);
  import game_pkg::*;

  state_t r_state;
  state_t w_state_nx;
  logic   w_clear;
  logic   w_finish;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_clear    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          w_state_nx = ST_WAIT_GUESS;
          w_clear    = 1'b1;
        end
      end
      ST_WAIT_GUESS: if (Guess_Valid) w_state_nx = ST_EVAL;
      ST_EVAL:       w_state_nx = ST_SAMPLE;
      ST_SAMPLE:     w_state_nx = w_finish ? ST_DONE : ST_WAIT_GUESS;
      default:       w_state_nx = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so no input reaches an output.
  assign Guess_Ready = (r_state == ST_WAIT_GUESS);
  assign Eval        = (r_state == ST_EVAL);
  assign Game_Over   = (r_state == ST_DONE);

  round_scoreboard #(.ROUNDS(ROUNDS)) u_scoreboard (
    .Clock          (Clock),
    .Reset          (Reset),
    .clear          (w_clear),
    .sample         (r_state == ST_SAMPLE),
    .cmp_code       (Cmp_Code),
    .hit_code       (Hit_Code),
    .round          (Round),
    .score_first    (Score_First),
    .score_second   (Score_Second),
    .history        (History),
    .winner         (Winner),
    .protocol_error (Protocol_Error),
    .finish         (w_finish)
  );

endmodule
`default_nettype wire

// File: tb/tb_game_referee.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_game_referee : directed scoreboard bench for game_referee.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_game_referee;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Guess_Valid = 1'b0;
  logic       Guess_Ready, Eval, Game_Over, Protocol_Error;
  logic [1:0] Cmp_Code = 2'b00;
  logic [1:0] Hit_Code = 2'b00;
  logic [2:0] Round, Score_First, Score_Second;
  logic [9:0] History;
  logic [1:0] Winner;

  game_referee #(.ROUNDS(5)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Guess_Valid(Guess_Valid),
    .Guess_Ready(Guess_Ready), .Eval(Eval), .Cmp_Code(Cmp_Code), .Hit_Code(Hit_Code),
    .Round(Round), .Score_First(Score_First), .Score_Second(Score_Second),
    .History(History), .Winner(Winner), .Game_Over(Game_Over),
    .Protocol_Error(Protocol_Error)
  );

  always #10 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] round;
    logic [2:0] sf;
    logic [2:0] ss;
    logic [9:0] hist;
    logic [1:0] win;
    logic       over;
    logic       perr;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  logic [2:0] m_round, m_sf, m_ss;
  logic [9:0] m_hist;
  logic [1:0] m_win;
  logic       m_over, m_perr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_round = 0; m_sf = 0; m_ss = 0; m_hist = 0; m_win = 0; m_over = 0; m_perr = 0;
  endtask

  task automatic model_round(input logic [1:0] cmp, input logic [1:0] hit);
    exp_t e;
    if (cmp == 2'b01 && m_sf < 5) m_sf = m_sf + 1;
    if (cmp == 2'b10 && m_ss < 5) m_ss = m_ss + 1;
    if (cmp == 2'b00) m_perr = 1'b1;
    if (m_round < 5) begin
      m_hist[2*m_round +: 2] = cmp;
      m_round = m_round + 1;
    end
    if (hit != 2'b00) begin
      m_win = hit; m_over = 1'b1;
    end else if (m_round == 5) begin
      m_win  = (m_sf > m_ss) ? 2'b01 : (m_sf < m_ss) ? 2'b10 : 2'b11;
      m_over = 1'b1;
    end
    e = '{m_round, m_sf, m_ss, m_hist, m_win, m_over, m_perr};
    q.push_back(e);
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
      return;
    end
    e = q.pop_front();
    check({tag, "_round"},  Round,          e.round);
    check({tag, "_sf"},     Score_First,    e.sf);
    check({tag, "_ss"},     Score_Second,   e.ss);
    check({tag, "_hist"},   History,        e.hist);
    check({tag, "_win"},    Winner,         e.win);
    check({tag, "_over"},   Game_Over,      e.over);
    check({tag, "_perr"},   Protocol_Error, e.perr);
    check({tag, "_ready"},  Guess_Ready,    !e.over);
  endtask

  task automatic start_game();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    model_clear();
    check("start_ready", Guess_Ready, 1);
    check("start_round", Round, 0);
    check("start_over",  Game_Over, 0);
    check("start_win",   Winner, 0);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!Guess_Ready && t < 20) begin
      @(negedge Clock);
      t++;
    end
    check("ready_wait", Guess_Ready, 1);
  endtask

  // Codes are presented only while the DUT is in SAMPLE; 00 elsewhere.
  task automatic do_round(input string tag, input logic [1:0] cmp, input logic [1:0] hit);
    wait_ready();
    Guess_Valid = 1'b1;
    @(negedge Clock);
    Guess_Valid = 1'b0;
    check({tag, "_eval_hi"}, Eval, 1);
    check({tag, "_ready_lo"}, Guess_Ready, 0);
    model_round(cmp, hit);
    @(negedge Clock);
    check({tag, "_eval_lo"}, Eval, 0);
    Cmp_Code = cmp;
    Hit_Code = hit;
    @(negedge Clock);
    Cmp_Code = 2'b00;
    Hit_Code = 2'b00;
    compare_pop(tag);
  endtask

  initial begin
    int last, evals;

    repeat (3) @(negedge Clock);
    check("rst_ready", Guess_Ready, 0);
    check("rst_eval",  Eval, 0);
    check("rst_round", Round, 0);
    check("rst_hist",  History, 0);
    check("rst_win",   Winner, 0);
    check("rst_over",  Game_Over, 0);
    check("rst_perr",  Protocol_Error, 0);
    Reset = 1'b0;
    @(negedge Clock);
    check("idle_ready", Guess_Ready, 0);

    // Five full rounds decided on points.
    start_game();
    do_round("g1r1", 2'b01, 2'b00);
    do_round("g1r2", 2'b01, 2'b00);
    do_round("g1r3", 2'b10, 2'b00);
    do_round("g1r4", 2'b11, 2'b00);
    do_round("g1r5", 2'b01, 2'b00);
    check("g1_hist_const", History, 10'b01_11_10_01_01);
    @(negedge Clock);
    check("g1_hold_win",  Winner, 2'b01);
    check("g1_hold_over", Game_Over, 1);

    // Exact hit by second player ends the game early.
    start_game();
    do_round("g2r1", 2'b01, 2'b00);
    do_round("g2r2", 2'b11, 2'b10);

    // Draw on points.
    start_game();
    do_round("g3r1", 2'b01, 2'b00);
    do_round("g3r2", 2'b10, 2'b00);
    do_round("g3r3", 2'b01, 2'b00);
    do_round("g3r4", 2'b10, 2'b00);
    do_round("g3r5", 2'b11, 2'b00);

    // Both hit on round 3.
    start_game();
    do_round("g4r1", 2'b01, 2'b00);
    do_round("g4r2", 2'b10, 2'b00);
    do_round("g4r3", 2'b01, 2'b11);

    // Invalid closeness code in round 1; error stays sticky.
    start_game();
    do_round("g5r1", 2'b00, 2'b00);
    do_round("g5r2", 2'b01, 2'b00);
    do_round("g5r3", 2'b01, 2'b00);
    do_round("g5r4", 2'b01, 2'b00);
    do_round("g5r5", 2'b01, 2'b00);

    // Guess_Valid held high: Eval every 3 cycles, mid-game Start ignored.
    start_game();
    Guess_Valid = 1'b1;
    Cmp_Code = 2'b01;
    last = -1;
    evals = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      if (Eval) begin
        check("bt_ready_in_eval", Guess_Ready, 0);
        if (last >= 0) check("bt_eval_period", c - last, 3);
        last = c;
        evals++;
      end
      Start = (c == 4 || c == 7);
    end
    Start = 1'b0;
    Guess_Valid = 1'b0;
    Cmp_Code = 2'b00;
    check("bt_evals", evals, 5);
    check("bt_round", Round, 5);
    check("bt_sf",    Score_First, 5);
    check("bt_hist",  History, 10'b01_01_01_01_01);
    check("bt_win",   Winner, 2'b01);
    check("bt_over",  Game_Over, 1);

    // Start beats a same-cycle Guess_Valid in DONE.
    Start = 1'b1;
    Guess_Valid = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    check("sd_ready", Guess_Ready, 1);
    check("sd_eval",  Eval, 0);
    check("sd_round", Round, 0);
    check("sd_over",  Game_Over, 0);
    @(negedge Clock);
    Guess_Valid = 1'b0;
    check("sd_eval_next", Eval, 1);

    // Asynchronous reset during SAMPLE of round 3.
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    start_game();
    do_round("rr1", 2'b01, 2'b00);
    do_round("rr2", 2'b10, 2'b00);
    wait_ready();
    Guess_Valid = 1'b1;
    @(negedge Clock);
    Guess_Valid = 1'b0;
    @(negedge Clock);
    Cmp_Code = 2'b01;
    #2 Reset = 1'b1;
    #1;
    check("ar_round", Round, 0);
    check("ar_sf",    Score_First, 0);
    check("ar_ss",    Score_Second, 0);
    check("ar_hist",  History, 0);
    check("ar_win",   Winner, 0);
    check("ar_over",  Game_Over, 0);
    check("ar_ready", Guess_Ready, 0);
    check("ar_eval",  Eval, 0);
    check("ar_perr",  Protocol_Error, 0);
    @(negedge Clock);
    Reset = 1'b0;
    Cmp_Code = 2'b00;
    @(negedge Clock);
    check("ar_idle_round", Round, 0);
    check("ar_idle_ready", Guess_Ready, 0);
    start_game();
    do_round("ar_r1", 2'b10, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
